// File: rtl/result_drainer_if.sv
//------------------------------------------------------------------------------
// Module   : result_drainer_if
// Brief    : Result stream (valid/ready/last) between the drainer and the host.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface result_drainer_if #(
  parameter int DATA_W = 128
) ();
  logic [DATA_W-1:0] tdata_o;
  logic              tvalid_o;
  logic              tready_i;
  logic              tlast_o;

  modport master (output tdata_o, output tvalid_o, output tlast_o, input  tready_i);
  modport slave  (input  tdata_o, input  tvalid_o, input  tlast_o, output tready_i);
endinterface

`default_nettype wire

// File: rtl/result_drainer.sv
//------------------------------------------------------------------------------
// Module   : result_drainer
// Brief    : Reads len_i words of buffer P from base_addr_i and streams them to
//            the host with tlast on the final word. A 2-entry skid FIFO hides
//            the 1-cycle read latency so the stream runs at 1 word/cycle.
//            Optional macro RESULT_DRAINER_PERF_EN adds stall_cnt_o.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_drainer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              done_o,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              enp_o,
  output logic              wep_o,
  output logic [ADDR_W-1:0] addrp_o,
  input  logic [DATA_W-1:0] datap_i,
  result_drainer_if.master  strm
`ifdef RESULT_DRAINER_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_issued;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_beat;
  logic              r_inflight;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;

  logic              w_tvalid;
  logic              w_pop;
  logic              w_tlast;
  logic              w_enp;
  logic              w_start_rd;
  logic              w_last_issue;
  logic [2:0]        w_used;
  logic [2:0]        w_limit;

  assign w_tvalid     = (r_cnt != 2'd0);
  assign w_pop        = w_tvalid && strm.tready_i;
  assign w_tlast      = w_tvalid && (r_beat == r_len - C_ONE);
  // A word leaving the FIFO this cycle frees its slot for a read issued now;
  // without it the loop cannot sustain one word per cycle.
  assign w_used       = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_limit      = 3'd2 + {2'b00, w_pop};
  assign w_enp        = (r_state == S_READ) && (w_used < w_limit);
  assign w_start_rd   = (r_state == S_IDLE) && start_i && (len_i != '0);
  assign w_last_issue = w_enp && (r_issued == r_len - C_ONE);

  assign done_o        = (r_state == S_DONE);
  assign enp_o         = w_enp;
  assign wep_o         = 1'b0;
  assign addrp_o       = r_addr;
  assign strm.tdata_o  = r_head;
  assign strm.tvalid_o = w_tvalid;
  assign strm.tlast_o  = w_tlast;

  // Next-state decode for the drain sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = (len_i != '0) ? S_READ : S_DONE;
      S_READ:  if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && w_tlast) w_state_nxt = S_DONE;
      S_DONE:  if (!start_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Address, issue/beat counters and the read-in-flight flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_issued   <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_enp;
      if (w_start_rd) begin
        r_addr   <= base_addr_i;
        r_len    <= len_i;
        r_issued <= '0;
        r_beat   <= '0;
      end else begin
        if (w_enp) begin
          r_addr   <= r_addr + C_ONE;
          r_issued <= r_issued + C_ONE;
        end
        if (w_pop) r_beat <= r_beat + C_ONE;
      end
    end
  end

  // Two-entry skid FIFO: r_head is the stream word, r_tail the second entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= datap_i;
          else               r_tail <= datap_i;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= datap_i;
          end else begin
            r_head <= r_tail;
            r_tail <= datap_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Returning read data must always find a free slot.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_inflight && (r_cnt == 2'd2) && !w_pop));

`ifdef RESULT_DRAINER_PERF_EN
  logic [31:0] r_stall;
  assign stall_cnt_o = r_stall;

  // Saturating count of cycles the sink holds off a valid word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                      r_stall <= '0;
    else if (w_start_rd)                              r_stall <= '0;
    else if (w_tvalid && !strm.tready_i && (r_stall != 32'hFFFF_FFFF))
                                                      r_stall <= r_stall + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_drainer.sv
//------------------------------------------------------------------------------
// Module   : tb_result_drainer
// Brief    : Scoreboard bench for result_drainer with a 1-cycle buffer P model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_result_drainer;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic              enp;
  logic              wep;
  logic [ADDR_W-1:0] addrp;
  logic [DATA_W-1:0] datap = '0;
`ifdef RESULT_DRAINER_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  result_drainer_if #(.DATA_W(DATA_W)) strm ();

  result_drainer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .done_o      (done),
    .base_addr_i (base_addr),
    .len_i       (len),
    .enp_o       (enp),
    .wep_o       (wep),
    .addrp_o     (addrp),
    .datap_i     (datap),
    .strm        (strm)
`ifdef RESULT_DRAINER_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pword(input logic [ADDR_W-1:0] a);
    return {8{a ^ 16'h5A3C}};
  endfunction

  // buffer P model: read data one cycle after the enable
  always @(posedge clk) if (enp) datap <= pword(addrp);

  int                checks = 0;
  int                errors = 0;
  exp_t              q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int                issue_cnt = 0;
  int                beat_cnt = 0;
  int                stall_seen = 0;
  int                mode = 0;
  int                ph = 0;
  int                first_enp = -1;
  int                first_beat = -1;
  int                last_beat = -1;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: drive tready for the coming edge, then check issues and beats.
  initial begin
    exp_t e;
    strm.tready_i = 1'b1;
    forever begin
      @(negedge clk);
      ph++;
      case (mode)
        0:       strm.tready_i = 1'b1;
        1:       strm.tready_i = (ph % 3 == 0);
        default: strm.tready_i = 1'b0;
      endcase
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (enp) begin
          chk("issue_addr", addrp, exp_addr);
          if (issue_cnt == 0) first_enp = ph;
          exp_addr++;
          issue_cnt++;
        end
        if (prev_stall) begin
          chk("hold_valid", strm.tvalid_o, 1);
          chk("hold_data", strm.tdata_o, prev_data);
        end
        if (strm.tvalid_o && strm.tready_i) begin
          if (beat_cnt == 0) first_beat = ph;
          last_beat = ph;
          beat_cnt++;
          chk("beat_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("beat_data", strm.tdata_o, e.d);
            chk("beat_last", strm.tlast_o, e.last);
          end
        end
        if (strm.tvalid_o && !strm.tready_i) stall_seen++;
        prev_stall = strm.tvalid_o && !strm.tready_i;
        prev_data  = strm.tdata_o;
      end
    end
  end

  // One complete transfer; returns cycles from start to done_o (and start cycle).
  task automatic xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                      input int md, output int lat, output int t0);
    logic [ADDR_W-1:0] a;
    int cyc;
    @(negedge clk); #2;
    mode = md;
    a = b;
    for (int i = 0; i < int'(l); i++) begin
      q.push_back('{d: pword(a), last: (i == int'(l) - 1)});
      a++;
    end
    exp_addr = b; issue_cnt = 0; beat_cnt = 0; stall_seen = 0;
    first_enp = -1; first_beat = -1; last_beat = -1;
    base_addr = b; len = l; start = 1'b1;
    t0 = ph;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk); #2;
      cyc++;
      if (cyc == 1) begin
        base_addr = 16'hDEAD;
        len       = 16'h0BAD;
      end
      if (done) break;
    end
    lat = ph - t0;
    chk("done_reached", done, 1);
    chk("queue_drained", q.size(), 0);
    chk("issue_count", issue_cnt, l);
    chk("beat_count", beat_cnt, l);
    repeat (2) @(negedge clk);
    #2;
    chk("done_hold", done, 1);
    start = 1'b0;
    @(negedge clk); #2;
    chk("done_clear", done, 0);
  endtask

  initial begin
    int lat, t0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_done", done, 0);
    chk("rst_enp", enp, 0);
    chk("rst_wep", wep, 0);
    chk("rst_tvalid", strm.tvalid_o, 0);
    chk("rst_tlast", strm.tlast_o, 0);
    chk("rst_addrp", addrp, 0);
    chk("rst_tdata", strm.tdata_o, 0);
    rst_n = 1'b1;

    // len=4 at 0x10 with the sink always ready
    xfer(16'h0010, 16'd4, 0, lat, t0);
    chk("l4_done_lat", lat, 7);
    chk("l4_enp_lat", first_enp - t0, 1);
    chk("l4_first_beat_lat", first_beat - t0, 3);
    chk("l4_last_beat_lat", last_beat - t0, 6);

    // zero-length request goes straight to DONE
    xfer(16'h0033, 16'd0, 0, lat, t0);
    chk("l0_done_lat", lat, 1);

    // back-pressure pattern 1,0,0,...
    xfer(16'h0100, 16'd6, 1, lat, t0);
`ifdef RESULT_DRAINER_PERF_EN
    chk("stall_cnt", stall_cnt, stall_seen);
`endif

    // address wrap at the top of buffer P
    xfer(16'hFFFE, 16'd3, 0, lat, t0);
    chk("wrap_done_lat", lat, 6);

    // reset mid-DRAIN with two words held in the FIFO
    @(negedge clk); #2;
    mode = 2;
    q.push_back('{d: pword(16'h0040), last: 1'b0});
    q.push_back('{d: pword(16'h0041), last: 1'b1});
    exp_addr = 16'h0040; issue_cnt = 0; beat_cnt = 0;
    base_addr = 16'h0040; len = 16'd2; start = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("pre_rst_valid", strm.tvalid_o, 1);
    chk("pre_rst_issues", issue_cnt, 2);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", strm.tvalid_o, 0);
    chk("arst_tdata", strm.tdata_o, 0);
    chk("arst_tlast", strm.tlast_o, 0);
    chk("arst_addrp", addrp, 0);
    chk("arst_enp", enp, 0);
    chk("arst_done", done, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    q.delete();
    mode = 0; beat_cnt = 0; issue_cnt = 0;
    repeat (10) @(negedge clk);
    #2;
    chk("post_rst_beats", beat_cnt, 0);
    chk("post_rst_issues", issue_cnt, 0);
    chk("post_rst_tvalid", strm.tvalid_o, 0);

    // a fresh transfer works after the abort
    xfer(16'h0020, 16'd5, 1, lat, t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", ph, 0);
    $fatal(1);
  end
endmodule

`default_nettype wire
